fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Owns the architectural PC and sequences instruction fetch from a variable-latency instruction memory.
//  Sits ahead of decode; branch/jump resolution returns redirect_valid/redirect_pc.
//  Provides a one-entry fetch output register with stall back-pressure, flush on redirect, and HLT detection.
//  After HLT the PC freezes until reset.
// PARAMETERS
//  RESET_PC    16'h0000  PC value loaded on reset
//  HLT_OPCODE  4'hF      instr[15:12] value that halts the core
//  ADDR_W      16        PC / address width
// PORTS
//  clk            in   1   sole clock; all state updates on rising edge
//  rst_n          in   1   synchronous, active-low reset
//  stall          in   1   decode cannot accept; hold if_* outputs
//  redirect_valid in   1   taken branch/jump resolved; flush and load redirect_pc
//  redirect_pc    in   16  new PC (bit 0 ignored, forced 0)
//  imem_req       out  1   fetch request; imem_addr valid while high
//  imem_addr      out  16  fetch address (= pc)
//  imem_ack       in   1   instruction returned this cycle; meaningful only while imem_req=1
//  imem_data      in   16  instruction word, valid with imem_ack
//  if_valid       out  1   if_instr/if_pc hold a live instruction
//  if_instr       out  16  fetched instruction
//  if_pc          out  16  address of if_instr
//  if_pc_plus2    out  16  if_pc + 2, for branch-target adder
//  halted         out  1   core halted (sticky until reset)
// BEHAVIOUR
//  Reset (rst_n=0 at edge): pc=RESET_PC, state=FETCH, if_valid=0, if_instr=0, if_pc=0, halted=0, bubble=0.
//   imem_req is 0 in the reset cycle.
//  States: FETCH, HALT. HALT is exited only by reset. rst_n overrides everything, in any state, mid-request.
//  consume = if_valid & ~stall.
//  imem_req = (state==FETCH) & ~bubble & ~redirect_valid & (~if_valid | ~stall).
//  Per-cycle priority: reset > redirect > halt > ack/consume.
//  Redirect: pc<=redirect_pc&~1; if_valid<=0; bubble<=1.
//   Any same-cycle imem_ack is discarded.
//   Next cycle imem_req=0; requests resume one cycle after that. Minimum redirect-to-req latency is 2 cycles.
//   Redirect applies while stalled. Redirect is ignored in HALT.
//  Halt: consume & if_instr[15:12]==HLT_OPCODE & ~redirect_valid -> state<=HALT, halted<=1, if_valid<=0.
//   pc holds the HLT address + 2 and is frozen. imem_req=0 thereafter.
//   A redirect in the same cycle wins (older branch squashes the HLT).
//  Ack (imem_req & imem_ack): if_instr<=imem_data, if_pc<=pc, if_valid<=1, pc<=pc+2.
//   Ack in the same cycle as request is legal (zero wait).
//  Consume without ack: if_valid<=0.
//  Stall with if_valid=1: if_* held bit-exact; no request issued, so no overflow is possible.
//  Arithmetic: pc+2 is modulo 2^16; 16'hFFFE wraps to 16'h0000, no flag.
//  if_pc_plus2 is combinational from if_pc.
//  Memory-side rule: imem_req may drop (on redirect) while a request is outstanding.
//   imem must tolerate abort. An ack while req=0 is ignored.
// STRUCTURE
//  fetch_pkg: state enum {FETCH, HALT}, HLT_OPCODE, ADDR_W, RESET_PC default.
//  Sub-module pc_incr: 16-bit +2 incrementer (built on CLA_16b, sub=0), instanced twice (pc, if_pc).
//  All else in one always block plus combinational req/consume logic.
// TESTING
//  Reset, zero-wait ack: imem_ack=1 every cycle, data 16'h1111/16'h2222.
//   -> imem_addr 0000,0002,0004; if_pc 0000 then 0002; if_valid from cycle 2.
//  2-cycle memory latency: ack every 3rd cycle.
//   -> imem_addr held stable while req=1; if_valid pulses, no duplicate if_pc.
//  Stall 3 cycles with if_valid=1, if_instr=16'hA123.
//   -> if_* unchanged, imem_req=0; on release, next fetch at if_pc+2.
//  redirect_valid=1, redirect_pc=16'h0041, ack same cycle.
//   -> ack data dropped, if_valid=0, req low 1 cycle, then imem_addr=16'h0040.
//  if_instr=16'hF000 at if_pc=16'h0010 consumed.
//   -> halted=1 next cycle, imem_req=0 forever, pc=16'h0012.
//   Same scenario with redirect in the same cycle -> no halt.
//  PC wrap: pc=16'hFFFE, ack -> if_pc=FFFE, next imem_addr=16'h0000.
//   rst_n=0 mid-wait -> req=0, pc=RESET_PC next cycle.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared types and default constants for the instruction fetch sequencer.
package fetch_sequencer_pkg;

    localparam int          DEF_ADDR_W     = 16;
    localparam logic [3:0]  DEF_HLT_OPCODE = 4'hF;
    localparam logic [15:0] DEF_RESET_PC   = 16'h0000;

    typedef enum logic {
        ST_FETCH,
        ST_HALT
    } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/ack bus between the fetch sequencer and imem.
interface fetch_sequencer_if
    import fetch_sequencer_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
);

    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              ack;
    logic [15:0]       data;

    modport master (output req, output addr, input ack, input data);
    modport slave  (input req, input addr, output ack, output data);

endinterface

// File: rtl/fetch_sequencer_pc_incr.sv
// Modulo-2^W "+2" incrementer used for the next PC and the branch-target base.
module fetch_sequencer_pc_incr #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    output logic [W-1:0] y
);

    // Carry out of the MSB is dropped: 16'hFFFE wraps to 16'h0000.
    assign y = a + W'(2);

endmodule

// File: rtl/fetch_sequencer.sv
// Owns the architectural PC, issues fetches to imem and holds one fetched
// instruction for decode, with stall, redirect flush and HLT detection.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEF_RESET_PC),
    parameter logic [3:0]        HLT_OPCODE = DEF_HLT_OPCODE
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    fetch_sequencer_if.master  imem,
    output logic               if_valid,
    output logic [15:0]        if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [ADDR_W-1:0]  if_pc_plus2,
    output logic               halted
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus2;
    logic              bubble;
    logic              consume;
    logic              take_ack;
    logic              take_halt;

    fetch_sequencer_pc_incr #(.W(ADDR_W)) u_pc_incr    (.a(pc),    .y(pc_plus2));
    fetch_sequencer_pc_incr #(.W(ADDR_W)) u_if_pc_incr (.a(if_pc), .y(if_pc_plus2));

    assign consume = if_valid & ~stall;

    // Gating with rst_n keeps the request low in the reset cycle itself.
    assign imem.req  = rst_n & (state_q == ST_FETCH) & ~bubble & ~redirect_valid
                     & (~if_valid | ~stall);
    assign imem.addr = pc;

    // An ack with req low (e.g. a late reply to an aborted fetch) is ignored.
    assign take_ack  = imem.req & imem.ack;
    assign take_halt = (state_q == ST_FETCH) & consume & ~redirect_valid
                     & (if_instr[15:12] == HLT_OPCODE);

    assign halted = (state_q == ST_HALT);

    // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (take_halt) begin
            state_d = ST_HALT;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Priority inside FETCH: redirect > halt > ack > consume. HALT freezes everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            bubble   <= 1'b0;
            if_valid <= 1'b0;
            if_instr <= '0;
            if_pc    <= '0;
        end else if (state_q == ST_FETCH) begin
            bubble <= 1'b0;
            if (redirect_valid) begin
                pc       <= redirect_pc & ~ADDR_W'(1);
                if_valid <= 1'b0;
                bubble   <= 1'b1;
            end else if (take_halt) begin
                // pc already points at HLT+2; any same-cycle ack is dropped.
                if_valid <= 1'b0;
            end else if (take_ack) begin
                if_instr <= imem.data;
                if_pc    <= pc;
                if_valid <= 1'b1;
                pc       <= pc_plus2;
            end else if (consume) begin
                if_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer with hand-computed expectations.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic [15:0] if_pc_plus2;
    logic        halted;

    int checks   = 0;
    int failures = 0;

    fetch_sequencer_if #(.ADDR_W(16)) imem ();

    fetch_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (imem),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc_plus2    (if_pc_plus2),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Apply inputs shortly after an edge and let combinational outputs settle.
    task automatic drive(input logic s, input logic rv, input logic [15:0] rpc,
                         input logic ak, input logic [15:0] d);
        stall          = s;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem.ack       = ak;
        imem.data      = d;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 16'h0, 0, 16'h0);
        check("rst_req_comb", imem.req, 0);
        tick();
        tick();
        check("rst_if_valid", if_valid, 0);
        check("rst_if_pc", if_pc, 16'h0000);
        check("rst_if_instr", if_instr, 16'h0000);
        check("rst_halted", halted, 0);
        check("rst_addr", imem.addr, 16'h0000);
        check("rst_req", imem.req, 0);

        // Zero-wait memory.
        rst_n = 1'b1;
        drive(0, 0, 16'h0, 1, 16'h1111);
        check("zw_req0", imem.req, 1);
        check("zw_addr0", imem.addr, 16'h0000);
        tick();
        check("zw_valid0", if_valid, 1);
        check("zw_pc0", if_pc, 16'h0000);
        check("zw_instr0", if_instr, 16'h1111);
        drive(0, 0, 16'h0, 1, 16'h2222);
        check("zw_req1", imem.req, 1);
        check("zw_addr1", imem.addr, 16'h0002);
        tick();
        check("zw_valid1", if_valid, 1);
        check("zw_pc1", if_pc, 16'h0002);
        check("zw_instr1", if_instr, 16'h2222);

        // Two-cycle latency: ack every third cycle.
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 16'h0, 0, 16'h0);
            check("lat_req_a", imem.req, 1);
            check("lat_addr_a", imem.addr, 16'h0004 + 16'(2 * k));
            tick();
            check("lat_valid_a", if_valid, 0);
            drive(0, 0, 16'h0, 0, 16'h0);
            check("lat_addr_b", imem.addr, 16'h0004 + 16'(2 * k));
            tick();
            check("lat_valid_b", if_valid, 0);
            drive(0, 0, 16'h0, 1, 16'h3000 + 16'(k));
            check("lat_req_c", imem.req, 1);
            check("lat_addr_c", imem.addr, 16'h0004 + 16'(2 * k));
            tick();
            check("lat_valid_c", if_valid, 1);
            check("lat_pc_c", if_pc, 16'h0004 + 16'(2 * k));
            check("lat_instr_c", if_instr, 16'h3000 + 16'(k));
        end

        // Stall with a live instruction.
        drive(0, 0, 16'h0, 1, 16'hA123);
        check("st_addr", imem.addr, 16'h0008);
        tick();
        check("st_pc", if_pc, 16'h0008);
        check("st_instr", if_instr, 16'hA123);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 16'h0, 1, 16'hBEEF);
            check("st_req_hold", imem.req, 0);
            tick();
            check("st_valid_hold", if_valid, 1);
            check("st_pc_hold", if_pc, 16'h0008);
            check("st_instr_hold", if_instr, 16'hA123);
        end
        drive(0, 0, 16'h0, 0, 16'h0);
        check("st_rel_req", imem.req, 1);
        check("st_rel_addr", imem.addr, 16'h000A);
        check("st_pc_plus2", if_pc_plus2, 16'h000A);

        // Redirect with a same-cycle ack.
        drive(0, 1, 16'h0041, 1, 16'hDEAD);
        check("rd_req", imem.req, 0);
        tick();
        check("rd_valid", if_valid, 0);
        check("rd_addr", imem.addr, 16'h0040);
        drive(0, 0, 16'h0, 1, 16'h4444);
        check("rd_bubble_req", imem.req, 0);
        tick();
        check("rd_bubble_valid", if_valid, 0);
        drive(0, 0, 16'h0, 1, 16'h4444);
        check("rd_resume_req", imem.req, 1);
        check("rd_resume_addr", imem.addr, 16'h0040);
        tick();
        check("rd_valid2", if_valid, 1);
        check("rd_pc2", if_pc, 16'h0040);
        check("rd_instr2", if_instr, 16'h4444);

        // HLT at 0x0010.
        drive(0, 1, 16'h0010, 0, 16'h0);
        tick();
        drive(0, 0, 16'h0, 0, 16'h0);
        tick();
        drive(0, 0, 16'h0, 1, 16'hF000);
        check("h_addr", imem.addr, 16'h0010);
        tick();
        check("h_pc", if_pc, 16'h0010);
        check("h_instr", if_instr, 16'hF000);
        drive(0, 0, 16'h0, 1, 16'h5555);
        check("h_req_consume", imem.req, 1);
        tick();
        check("h_halted", halted, 1);
        check("h_valid", if_valid, 0);
        check("h_addr_frozen", imem.addr, 16'h0012);
        check("h_req", imem.req, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, (i == 1), 16'h0100, 1, 16'h5555);
            tick();
            check("h_req_forever", imem.req, 0);
            check("h_addr_forever", imem.addr, 16'h0012);
            check("h_sticky", halted, 1);
        end
        rst_n = 1'b0;
        drive(0, 0, 16'h0, 0, 16'h0);
        tick();
        check("h_rst_halted", halted, 0);
        check("h_rst_addr", imem.addr, 16'h0000);
        rst_n = 1'b1;

        // HLT squashed by a same-cycle redirect.
        drive(0, 1, 16'h0010, 0, 16'h0);
        tick();
        drive(0, 0, 16'h0, 0, 16'h0);
        tick();
        drive(0, 0, 16'h0, 1, 16'hF000);
        tick();
        check("hs_pc", if_pc, 16'h0010);
        drive(0, 1, 16'h0020, 1, 16'h5555);
        tick();
        check("hs_halted", halted, 0);
        check("hs_valid", if_valid, 0);
        check("hs_addr", imem.addr, 16'h0020);
        drive(0, 0, 16'h0, 0, 16'h0);
        check("hs_bubble_req", imem.req, 0);
        tick();
        check("hs_resume_req", imem.req, 1);
        check("hs_resume_addr", imem.addr, 16'h0020);

        // PC wrap; redirect bit 0 forced low.
        drive(0, 1, 16'hFFFF, 0, 16'h0);
        tick();
        check("wr_addr", imem.addr, 16'hFFFE);
        drive(0, 0, 16'h0, 0, 16'h0);
        tick();
        drive(0, 0, 16'h0, 1, 16'h6666);
        check("wr_req", imem.req, 1);
        tick();
        check("wr_if_pc", if_pc, 16'hFFFE);
        check("wr_if_pc_plus2", if_pc_plus2, 16'h0000);
        check("wr_next_addr", imem.addr, 16'h0000);
        drive(0, 0, 16'h0, 1, 16'h7777);
        tick();
        check("wr_pc0", if_pc, 16'h0000);
        check("wr_addr2", imem.addr, 16'h0002);

        // Reset while a fetch is outstanding.
        drive(0, 0, 16'h0, 0, 16'h0);
        tick();
        check("mw_req", imem.req, 1);
        check("mw_addr", imem.addr, 16'h0002);
        rst_n = 1'b0;
        #1;
        check("mw_rst_req", imem.req, 0);
        tick();
        check("mw_rst_addr", imem.addr, 16'h0000);
        check("mw_rst_valid", if_valid, 0);
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
